bin_to_bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 49 ++++
 rtl/bcd_dabble_step.sv | 35 +++
 rtl/bin_to_bcd_seq.sv | 133 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: digit width,
// FSM state encoding, digit-count sizing and significant-digit counting.
package bcd_pkg;

  localparam int DIGIT_W    = 4;
  // Widest BCD result the significant-digit helper can inspect.
  localparam int MAX_DIGITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest digit count d such that 10^d > 2^bin_w - 1.
  function automatic int min_digits(input int bin_w);
    longint unsigned max_val;
    longint unsigned pow10;
    int              d;
    max_val = (64'd1 << bin_w) - 64'd1;
    pow10   = 64'd1;
    d       = 0;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= max_val) begin
        pow10 = pow10 * 64'd10;
        d     = d + 1;
      end else begin
        d     = d;
      end
    end
    return d;
  endfunction

  // Index of the highest non-zero digit plus one; an all-zero value counts as 1.
  function automatic int sig_digits(input logic [DIGIT_W*MAX_DIGITS-1:0] bcd,
                                    input int digits);
    int n;
    n = 1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if ((i < digits) && (bcd[i*DIGIT_W +: DIGIT_W] != 4'd0)) begin
        n = i + 1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift the
// concatenation {digits, mag} left by one bit.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic [DIGIT_W*DIGITS-1:0] digits_in,
  input  logic [BIN_W-1:0]          mag_in,
  output logic [DIGIT_W*DIGITS-1:0] digits_out,
  output logic [BIN_W-1:0]          mag_out
);

  logic [DIGIT_W*DIGITS-1:0] adjusted;
  // Carry out of the top digit; always zero for a legally sized DIGITS.
  logic                      unused_carry;

  // Per-digit add-3 correction; digits never carry into one another here.
  always_comb begin
    adjusted = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_in[i*DIGIT_W +: DIGIT_W] >= 4'd5) begin
        adjusted[i*DIGIT_W +: DIGIT_W] = digits_in[i*DIGIT_W +: DIGIT_W] + 4'd3;
      end else begin
        adjusted[i*DIGIT_W +: DIGIT_W] = digits_in[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign digits_out   = {adjusted[DIGIT_W*DIGITS-2:0], mag_in[BIN_W-1]};
  assign mag_out      = {mag_in[BIN_W-2:0], 1'b0};
  assign unused_carry = adjusted[DIGIT_W*DIGITS-1];

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter with valid/ready on both sides, an
// optional two's-complement input mode and a significant-digit count.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIN_W-1:0]             in_bin,
  input  logic                         in_signed,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          out_bcd,
  output logic                         out_neg,
  output logic [$clog2(DIGITS+1)-1:0]  out_ndigits
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int NDW   = $clog2(DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Reject configurations that cannot hold every input value.
  generate
    if ((BIN_W < 4) || (BIN_W > 32)) begin : g_bad_width
      $error("bin_to_bcd_seq: BIN_W must lie in 4..32");
    end
    if ((DIGITS < min_digits(BIN_W)) || (DIGITS > MAX_DIGITS)) begin : g_bad_digits
      $error("bin_to_bcd_seq: DIGITS too small for BIN_W or above MAX_DIGITS");
    end
  endgenerate

  state_t                      state;
  logic [CNT_W-1:0]            count;
  logic [BIN_W-1:0]            mag;
  logic [BCD_W-1:0]            digits;

  logic [BIN_W-1:0]            in_mag;
  logic                        in_is_neg;
  logic [BCD_W-1:0]            step_digits;
  logic [BIN_W-1:0]            step_mag;
  logic [DIGIT_W*MAX_DIGITS-1:0] step_ext;
  logic [NDW-1:0]              step_ndigits;

  // Magnitude and sign of the presented word; the most negative value maps
  // to 2^(BIN_W-1), which still fits the unsigned BIN_W-bit magnitude.
  always_comb begin
    in_is_neg = in_signed & in_bin[BIN_W-1];
    if (in_is_neg) begin
      in_mag = ~in_bin + BIN_W'(1);
    end else begin
      in_mag = in_bin;
    end
  end

  bcd_dabble_step #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_step (
    .digits_in  (digits),
    .mag_in     (mag),
    .digits_out (step_digits),
    .mag_out    (step_mag)
  );

  // Significant-digit count of the digits produced by the current iteration.
  always_comb begin
    step_ext            = '0;
    step_ext[BCD_W-1:0] = step_digits;
    step_ndigits        = NDW'(sig_digits(step_ext, DIGITS));
  end

  // Handshake FSM, iteration counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      mag         <= '0;
      digits      <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_bcd     <= '0;
      out_neg     <= 1'b0;
      out_ndigits <= NDW'(1);
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mag      <= in_mag;
            out_neg  <= in_is_neg;
            digits   <= '0;
            count    <= CNT_W'(BIN_W);
            in_ready <= 1'b0;
            state    <= SHIFT;
          end else begin
            state    <= IDLE;
          end
        end
        SHIFT: begin
          digits <= step_digits;
          mag    <= step_mag;
          count  <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            out_bcd     <= step_digits;
            out_ndigits <= step_ndigits;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            state       <= SHIFT;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            state     <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised self-checking bench for bin_to_bcd_seq: a 16-bit/5-digit and an
// 8-bit/3-digit instance checked against a divide-by-ten reference model.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // 16-bit / 5-digit instance
  logic        a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready, a_out_neg;
  logic [15:0] a_in_bin;
  logic [19:0] a_out_bcd;
  logic [2:0]  a_out_ndigits;

  // 8-bit / 3-digit instance
  logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready, b_out_neg;
  logic [7:0]  b_in_bin;
  logic [11:0] b_out_bcd;
  logic [1:0]  b_out_ndigits;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_bin(a_in_bin), .in_signed(a_in_signed), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_bcd(a_out_bcd), .out_neg(a_out_neg),
    .out_ndigits(a_out_ndigits)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_bin(b_in_bin), .in_signed(b_in_signed), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_bcd(b_out_bcd), .out_neg(b_out_neg),
    .out_ndigits(b_out_ndigits)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic        g_ready(input int w); return w ? b_in_ready  : a_in_ready;  endfunction
  function automatic logic        g_valid(input int w); return w ? b_out_valid : a_out_valid; endfunction
  function automatic logic        g_neg  (input int w); return w ? b_out_neg   : a_out_neg;   endfunction
  function automatic logic [63:0] g_bcd  (input int w); return w ? 64'(b_out_bcd) : 64'(a_out_bcd); endfunction
  function automatic logic [63:0] g_nd   (input int w); return w ? 64'(b_out_ndigits) : 64'(a_out_ndigits); endfunction

  // Reference: decimal digits by repeated division of the signed/unsigned magnitude.
  function automatic void ref_model(input int w, input int d, input logic [31:0] v, input logic s,
                                    output logic [63:0] bcd, output logic neg, output int nd);
    longint unsigned m;
    longint unsigned dig;
    m   = longint'(v) & ((64'd1 << w) - 64'd1);
    neg = s && v[w-1];
    if (neg) m = (64'd1 << w) - m;
    bcd = '0;
    nd  = 1;
    for (int i = 0; i < d; i++) begin
      dig = m % 10;
      bcd = bcd | (dig << (4 * i));
      if (dig != 0) nd = i + 1;
      m = m / 10;
    end
  endfunction

  task automatic drive_in(input int w, input logic vld, input logic [31:0] v, input logic s);
    if (w != 0) begin
      b_in_valid = vld; b_in_bin = v[7:0]; b_in_signed = s;
    end else begin
      a_in_valid = vld; a_in_bin = v[15:0]; a_in_signed = s;
    end
  endtask

  task automatic drive_out_ready(input int w, input logic r);
    if (w != 0) b_out_ready = r;
    else        a_out_ready = r;
  endtask

  // Full conversion: starts and ends #1 after a rising edge. With a pending
  // value, in_valid is raised again during the stall to probe backpressure.
  task automatic convert(input int w, input logic [31:0] v, input logic s, input int stall,
                         input logic pend, input logic [31:0] pv, input logic ps);
    logic [63:0] eb;
    logic        en;
    int          end_nd;
    int          bw;
    int          n;
    int          lat;
    bw = (w != 0) ? 8 : 16;
    ref_model(bw, (w != 0) ? 3 : 5, v, s, eb, en, end_nd);
    drive_in(w, 1'b1, v, s);
    n = 0;
    while (!g_ready(w) && n < 100) begin @(posedge clk); #1; n++; end
    check("accept_timeout", 64'(n < 100), 64'd1);
    @(posedge clk); #1;
    drive_in(w, 1'b0, v, s);
    check("busy_ready", 64'(g_ready(w)), 64'd0);
    lat = 0;
    while (!g_valid(w) && lat < 200) begin @(posedge clk); #1; lat++; end
    check("latency", 64'(lat), 64'(bw));
    check("bcd", g_bcd(w), eb);
    check("neg", 64'(g_neg(w)), 64'(en));
    check("ndigits", g_nd(w), 64'(end_nd));
    if (pend) drive_in(w, 1'b1, pv, ps);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(g_valid(w)), 64'd1);
      check("stall_bcd", g_bcd(w), eb);
      check("stall_ready", 64'(g_ready(w)), 64'd0);
    end
    drive_out_ready(w, 1'b1);
    @(posedge clk); #1;
    drive_out_ready(w, 1'b0);
    check("drop_valid", 64'(g_valid(w)), 64'd0);
    check("idle_ready", 64'(g_ready(w)), 64'd1);
  endtask

  initial begin
    logic [31:0] rv;
    rst_n = 1'b0;
    drive_in(0, 1'b0, 32'd0, 1'b0);
    drive_in(1, 1'b0, 32'd0, 1'b0);
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(a_in_ready), 64'd1);
    check("rst_valid", 64'(a_out_valid), 64'd0);
    check("rst_bcd", 64'(a_out_bcd), 64'd0);
    check("rst_neg", 64'(a_out_neg), 64'd0);
    check("rst_nd", 64'(a_out_ndigits), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner values on the 16-bit instance
    convert(0, 32'd0,      1'b0, 0, 1'b0, 32'd0, 1'b0);
    convert(0, 32'd65535,  1'b0, 0, 1'b0, 32'd0, 1'b0);
    convert(0, 32'd1234,   1'b0, 2, 1'b0, 32'd0, 1'b0);
    convert(0, 32'h8000,   1'b1, 0, 1'b0, 32'd0, 1'b0);
    convert(0, 32'hFFFF,   1'b1, 0, 1'b0, 32'd0, 1'b0);
    convert(0, 32'h7FFF,   1'b1, 0, 1'b0, 32'd0, 1'b0);

    // Backpressure with a pending word, which must only go in afterwards
    convert(0, 32'd4321,   1'b0, 10, 1'b1, 32'd907, 1'b0);
    convert(0, 32'd907,    1'b0, 0, 1'b0, 32'd0, 1'b0);

    // 8-bit instance: full unsigned sweep
    for (int v = 0; v < 256; v++) convert(1, 32'(v), 1'b0, 0, 1'b0, 32'd0, 1'b0);
    convert(1, 32'h80, 1'b1, 1, 1'b0, 32'd0, 1'b0);

    // Randomised mixed signed/unsigned traffic on both instances
    for (int i = 0; i < 150; i++) begin
      rv = $urandom;
      convert(0, rv, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, 32'd0, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      rv = $urandom;
      convert(1, rv, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, 32'd0, 1'b0);
    end

    // Reset in the middle of converting 9999
    drive_in(0, 1'b1, 32'd9999, 1'b0);
    @(posedge clk); #1;
    drive_in(0, 1'b0, 32'd0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(a_out_valid), 64'd0);
    check("mid_rst_ready", 64'(a_in_ready), 64'd1);
    check("mid_rst_bcd", 64'(a_out_bcd), 64'd0);
    check("mid_rst_nd", 64'(a_out_ndigits), 64'd1);
    check("mid_rst_neg", 64'(a_out_neg), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("no_stale_valid", 64'(a_out_valid), 64'd0);
    end
    convert(0, 32'd42, 1'b0, 0, 1'b0, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
